// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, state
// encoding, ALU / write-back selector encodings and the control bundle.
package ctrl_pkg;

    // Opcodes carried in the datapath IR
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_ADDI = 4'd7;
    localparam logic [3:0] OP_LI   = 4'd8;
    localparam logic [3:0] OP_LW   = 4'd9;
    localparam logic [3:0] OP_SW   = 4'd10;
    localparam logic [3:0] OP_BEQ  = 4'd11;
    localparam logic [3:0] OP_BNE  = 4'd12;
    localparam logic [3:0] OP_BLT  = 4'd13;
    localparam logic [3:0] OP_JMP  = 4'd14;
    localparam logic [3:0] OP_HALT = 4'd15;

    // ALU operation select
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SHL = 3'b101;
    localparam logic [2:0] ALU_SHR = 3'b110;

    // Register-file write data select
    localparam logic [2:0] RDW_ALU = 3'b000;
    localparam logic [2:0] RDW_MEM = 3'b001;
    localparam logic [2:0] RDW_IMM = 3'b010;

    typedef enum logic [3:0] {
        ST_RST      = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_R   = 4'd3,
        ST_EXEC_I   = 4'd4,
        ST_WB_ALU   = 4'd5,
        ST_WB_IMM   = 4'd6,
        ST_MEM_ADDR = 4'd7,
        ST_MEM_RD   = 4'd8,
        ST_WB_MEM   = 4'd9,
        ST_MEM_WR   = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_BR_TAKE  = 4'd12,
        ST_JUMP     = 4'd13,
        ST_HALT     = 4'd14
    } state_t;

    // Full set of datapath strobes plus the halt flag
    typedef struct packed {
        logic [1:0] num_bits;
        logic       imm_shift;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [2:0] alu_op;
        logic       write_enable;
        logic       d_or_s;
        logic       mem_write;
        logic       mem_read;
        logic       pc_write;
        logic       pc_source;
        logic [2:0] reg_data_write;
        logic       load_inst;
        logic       mem_addr_sel;
        logic       ir_write;
        logic       halted;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = ctrl_t'(21'd0);

    // Branch resolution: cmp[0] = equal, cmp[1] = A<B signed
    function automatic logic branch_take(input logic [3:0] op, input logic [1:0] cmp);
        branch_take = ((op == OP_BEQ) &&  cmp[0]) ||
                      ((op == OP_BNE) && !cmp[0]) ||
                      ((op == OP_BLT) &&  cmp[1]);
    endfunction

endpackage

// File: rtl/ctrl_retire_cnt.sv
// Saturating retired-instruction counter with asynchronous clear.
module ctrl_retire_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_r;

    // Count increment strobes, sticking at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= CNT_ZERO;
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/control_fsm.sv
// Multicycle control unit for the step3 datapath. Outputs are registered
// from a decode of the next state, so they are a Moore function of the
// current state and clear asynchronously with the state on reset.
module control_fsm #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [3:0]       op,
    input  logic [1:0]       cmpRst,
    output logic [1:0]       numBits,
    output logic             immShift,
    output logic             ALUSrcA,
    output logic             ALUSrcB,
    output logic [2:0]       ALUOp,
    output logic             writeEnable,
    output logic             DOrS,
    output logic             memEnableWrite,
    output logic             memEnableRead,
    output logic             PCWriteEnable,
    output logic             PCSource,
    output logic [2:0]       regDataWrite,
    output logic             loadInst,
    output logic             memAddrSel,
    output logic             IRWrite,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    import ctrl_pkg::*;

    state_t state_r;
    state_t state_next_s;
    ctrl_t  ctrl_r;
    ctrl_t  ctrl_next_s;
    logic   retire_inc_s;
    logic   take_s;

    // Next-state selection and retire strobe generation
    always_comb begin
        state_next_s = ST_FETCH;
        retire_inc_s = 1'b0;
        take_s       = branch_take(op, cmpRst);
        case (state_r)
            ST_RST:    state_next_s = ST_FETCH;
            ST_FETCH:  state_next_s = ST_DECODE;
            ST_DECODE: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR,
                    OP_XOR, OP_SHL, OP_SHR:    state_next_s = ST_EXEC_R;
                    OP_ADDI:                   state_next_s = ST_EXEC_I;
                    OP_LI:                     state_next_s = ST_WB_IMM;
                    OP_LW, OP_SW:              state_next_s = ST_MEM_ADDR;
                    OP_BEQ, OP_BNE, OP_BLT:    state_next_s = ST_BRANCH;
                    OP_JMP:                    state_next_s = ST_JUMP;
                    OP_HALT: begin
                        state_next_s = ST_HALT;
                        retire_inc_s = 1'b1;
                    end
                    default:                   state_next_s = ST_FETCH;
                endcase
            end
            ST_EXEC_R, ST_EXEC_I: state_next_s = ST_WB_ALU;
            ST_WB_ALU, ST_WB_IMM, ST_WB_MEM,
            ST_MEM_WR, ST_BR_TAKE, ST_JUMP: begin
                state_next_s = ST_FETCH;
                retire_inc_s = 1'b1;
            end
            ST_MEM_ADDR: begin
                if (op == OP_LW) begin
                    state_next_s = ST_MEM_RD;
                end else begin
                    state_next_s = ST_MEM_WR;
                end
            end
            ST_MEM_RD: state_next_s = ST_WB_MEM;
            ST_BRANCH: begin
                if (take_s) begin
                    state_next_s = ST_BR_TAKE;
                end else begin
                    state_next_s = ST_FETCH;
                    retire_inc_s = 1'b1;
                end
            end
            ST_HALT:   state_next_s = ST_HALT;
            // Corrupted state encoding resumes at instruction fetch
            default:   state_next_s = ST_FETCH;
        endcase
    end

    // Control strobes for the state being entered on the next edge
    always_comb begin
        ctrl_next_s = CTRL_IDLE;
        case (state_next_s)
            ST_FETCH: begin
                ctrl_next_s.mem_read = 1'b1;
                ctrl_next_s.ir_write = 1'b1;
            end
            ST_DECODE, ST_BR_TAKE: begin
                ctrl_next_s.imm_shift = 1'b1;
                ctrl_next_s.alu_op    = ALU_ADD;
                ctrl_next_s.alu_src_b = 1'b1;
                ctrl_next_s.num_bits  = (state_next_s == ST_DECODE) ? 2'b11 : 2'b10;
                ctrl_next_s.pc_write  = 1'b1;
            end
            ST_EXEC_R: begin
                ctrl_next_s.alu_op    = op[2:0];
                ctrl_next_s.alu_src_a = 1'b1;
            end
            ST_EXEC_I: begin
                ctrl_next_s.alu_op    = ALU_ADD;
                ctrl_next_s.alu_src_a = 1'b1;
                ctrl_next_s.alu_src_b = 1'b1;
                ctrl_next_s.num_bits  = 2'b01;
            end
            ST_WB_ALU: begin
                ctrl_next_s.reg_data_write = RDW_ALU;
                ctrl_next_s.write_enable   = 1'b1;
                ctrl_next_s.d_or_s         = 1'b1;
            end
            ST_WB_IMM: begin
                ctrl_next_s.load_inst      = 1'b1;
                ctrl_next_s.num_bits       = 2'b01;
                ctrl_next_s.reg_data_write = RDW_IMM;
                ctrl_next_s.write_enable   = 1'b1;
                ctrl_next_s.d_or_s         = 1'b1;
            end
            ST_MEM_ADDR: begin
                ctrl_next_s.alu_op    = ALU_ADD;
                ctrl_next_s.alu_src_a = 1'b1;
                ctrl_next_s.alu_src_b = 1'b1;
                ctrl_next_s.num_bits  = 2'b00;
            end
            ST_MEM_RD: begin
                ctrl_next_s.mem_addr_sel = 1'b1;
                ctrl_next_s.mem_read     = 1'b1;
            end
            ST_WB_MEM: begin
                ctrl_next_s.reg_data_write = RDW_MEM;
                ctrl_next_s.write_enable   = 1'b1;
                ctrl_next_s.d_or_s         = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl_next_s.mem_addr_sel = 1'b1;
                ctrl_next_s.mem_write    = 1'b1;
                ctrl_next_s.d_or_s       = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_next_s.alu_op    = ALU_SUB;
                ctrl_next_s.alu_src_a = 1'b1;
            end
            ST_JUMP: begin
                ctrl_next_s.num_bits  = 2'b10;
                ctrl_next_s.pc_write  = 1'b1;
                ctrl_next_s.pc_source = 1'b1;
            end
            ST_HALT: ctrl_next_s.halted = 1'b1;
            default: ctrl_next_s = CTRL_IDLE;
        endcase
    end

    // State and output registers; reset clears every strobe immediately
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_RST;
            ctrl_r  <= CTRL_IDLE;
        end else begin
            state_r <= state_next_s;
            ctrl_r  <= ctrl_next_s;
        end
    end

    ctrl_retire_cnt #(.CNT_W(CNT_W)) u_retire_cnt (
        .clk   (CLK),
        .rst_n (RST_N),
        .inc   (retire_inc_s),
        .count (retired)
    );

    assign numBits        = ctrl_r.num_bits;
    assign immShift       = ctrl_r.imm_shift;
    assign ALUSrcA        = ctrl_r.alu_src_a;
    assign ALUSrcB        = ctrl_r.alu_src_b;
    assign ALUOp          = ctrl_r.alu_op;
    assign writeEnable    = ctrl_r.write_enable;
    assign DOrS           = ctrl_r.d_or_s;
    assign memEnableWrite = ctrl_r.mem_write;
    assign memEnableRead  = ctrl_r.mem_read;
    assign PCWriteEnable  = ctrl_r.pc_write;
    assign PCSource       = ctrl_r.pc_source;
    assign regDataWrite   = ctrl_r.reg_data_write;
    assign loadInst       = ctrl_r.load_inst;
    assign memAddrSel     = ctrl_r.mem_addr_sel;
    assign IRWrite        = ctrl_r.ir_write;
    assign halted         = ctrl_r.halted;

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: per-instruction expected control
// sequences built from the opcode table, random instruction streams, halt,
// async reset mid-store, and counter saturation on a narrow second instance.
module tb_control_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  op;
    logic [1:0]  cmpRst;

    logic [1:0]  nb_a, nb_b;
    logic        ims_a, sa_a, sb_a, we_a, ds_a, mw_a, mr_a, pcw_a, pcs_a, li_a, mas_a, irw_a, h_a;
    logic        ims_b, sa_b, sb_b, we_b, ds_b, mw_b, mr_b, pcw_b, pcs_b, li_b, mas_b, irw_b, h_b;
    logic [2:0]  aop_a, rdw_a, aop_b, rdw_b;
    logic [15:0] ret_a;
    logic [1:0]  ret_b;
    logic [20:0] vec_a, vec_b;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    logic [20:0] exp_q[$];

    always #5 clk = ~clk;

    control_fsm #(.CNT_W(16)) dut (
        .CLK(clk), .RST_N(rst_n), .op(op), .cmpRst(cmpRst),
        .numBits(nb_a), .immShift(ims_a), .ALUSrcA(sa_a), .ALUSrcB(sb_a), .ALUOp(aop_a),
        .writeEnable(we_a), .DOrS(ds_a), .memEnableWrite(mw_a), .memEnableRead(mr_a),
        .PCWriteEnable(pcw_a), .PCSource(pcs_a), .regDataWrite(rdw_a), .loadInst(li_a),
        .memAddrSel(mas_a), .IRWrite(irw_a), .halted(h_a), .retired(ret_a)
    );

    control_fsm #(.CNT_W(2)) dut_sat (
        .CLK(clk), .RST_N(rst_n), .op(op), .cmpRst(cmpRst),
        .numBits(nb_b), .immShift(ims_b), .ALUSrcA(sa_b), .ALUSrcB(sb_b), .ALUOp(aop_b),
        .writeEnable(we_b), .DOrS(ds_b), .memEnableWrite(mw_b), .memEnableRead(mr_b),
        .PCWriteEnable(pcw_b), .PCSource(pcs_b), .regDataWrite(rdw_b), .loadInst(li_b),
        .memAddrSel(mas_b), .IRWrite(irw_b), .halted(h_b), .retired(ret_b)
    );

    assign vec_a = {nb_a, ims_a, sa_a, sb_a, aop_a, we_a, ds_a, mw_a, mr_a, pcw_a, pcs_a, rdw_a, li_a, mas_a, irw_a, h_a};
    assign vec_b = {nb_b, ims_b, sa_b, sb_b, aop_b, we_b, ds_b, mw_b, mr_b, pcw_b, pcs_b, rdw_b, li_b, mas_b, irw_b, h_b};

    // Pack one cycle's expected strobes in the same order as vec_a
    function automatic logic [20:0] pk(input int nb, input int ims, input int sa, input int sb,
                                       input int aop, input int we, input int ds, input int mw,
                                       input int mr, input int pcw, input int pcs, input int rdw,
                                       input int li, input int mas, input int irw, input int h);
        pk = {nb[1:0], ims[0], sa[0], sb[0], aop[2:0], we[0], ds[0], mw[0], mr[0],
              pcw[0], pcs[0], rdw[2:0], li[0], mas[0], irw[0], h[0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected retired value for a counter of the given width
    function automatic logic [31:0] exp_ret(input int n, input int maxv);
        exp_ret = (n > maxv) ? maxv : n;
    endfunction

    task automatic chk_ret(input string tag);
        chk({tag, "_ret16"}, {16'd0, ret_a}, exp_ret(n_done, 65535));
        chk({tag, "_ret2"},  {30'd0, ret_b}, exp_ret(n_done, 3));
    endtask

    // Cycle-by-cycle strobe list of one instruction, FETCH first
    task automatic build(input logic [3:0] o, input logic [1:0] c);
        logic tk;
        int   a;
        a  = int'(o[2:0]);
        tk = (o == 4'd11 && c[0]) || (o == 4'd12 && !c[0]) || (o == 4'd13 && c[1]);
        exp_q.delete();
        exp_q.push_back(pk(0,0,0,0,0,0,0,0,1,0,0,0,0,0,1,0));
        exp_q.push_back(pk(3,1,0,1,0,0,0,0,0,1,0,0,0,0,0,0));
        if (o <= 4'd6) begin
            exp_q.push_back(pk(0,0,1,0,a,0,0,0,0,0,0,0,0,0,0,0));
            exp_q.push_back(pk(0,0,0,0,0,1,1,0,0,0,0,0,0,0,0,0));
        end else if (o == 4'd7) begin
            exp_q.push_back(pk(1,0,1,1,0,0,0,0,0,0,0,0,0,0,0,0));
            exp_q.push_back(pk(0,0,0,0,0,1,1,0,0,0,0,0,0,0,0,0));
        end else if (o == 4'd8) begin
            exp_q.push_back(pk(1,0,0,0,0,1,1,0,0,0,0,2,1,0,0,0));
        end else if (o == 4'd9) begin
            exp_q.push_back(pk(0,0,1,1,0,0,0,0,0,0,0,0,0,0,0,0));
            exp_q.push_back(pk(0,0,0,0,0,0,0,0,1,0,0,0,0,1,0,0));
            exp_q.push_back(pk(0,0,0,0,0,1,1,0,0,0,0,1,0,0,0,0));
        end else if (o == 4'd10) begin
            exp_q.push_back(pk(0,0,1,1,0,0,0,0,0,0,0,0,0,0,0,0));
            exp_q.push_back(pk(0,0,0,0,0,0,1,1,0,0,0,0,0,1,0,0));
        end else if (o <= 4'd13) begin
            exp_q.push_back(pk(0,0,1,0,1,0,0,0,0,0,0,0,0,0,0,0));
            if (tk) exp_q.push_back(pk(2,1,0,1,0,0,0,0,0,1,0,0,0,0,0,0));
        end else begin
            exp_q.push_back(pk(2,0,0,0,0,0,0,0,0,1,1,0,0,0,0,0));
        end
    endtask

    // Run one instruction starting at a FETCH-cycle negedge; ends at the next FETCH
    task automatic run_instr(input logic [3:0] o, input logic [1:0] c);
        build(o, c);
        chk($sformatf("op%0d_k0", o), {11'd0, vec_a}, {11'd0, exp_q[0]});
        chk_ret($sformatf("op%0d_start", o));
        op     = o;
        cmpRst = c;
        for (int k = 1; k < exp_q.size(); k++) begin
            @(negedge clk);
            chk($sformatf("op%0d_c%0d_k%0d", o, c, k), {11'd0, vec_a}, {11'd0, exp_q[k]});
            chk($sformatf("sat_op%0d_k%0d", o, k), {11'd0, vec_b}, {11'd0, exp_q[k]});
        end
        n_done++;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n  = 1'b0;
        op     = 4'd0;
        cmpRst = 2'd0;
        repeat (2) @(negedge clk);
        chk("reset_vec", {11'd0, vec_a}, 32'd0);
        chk_ret("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed: ADD, LW, SW, BEQ taken / not taken, BLT taken
        run_instr(4'd0, 2'd0);
        run_instr(4'd9, 2'd0);
        run_instr(4'd10, 2'd0);
        run_instr(4'd11, 2'b01);
        run_instr(4'd11, 2'b00);
        run_instr(4'd13, 2'b10);
        run_instr(4'd12, 2'b01);
        run_instr(4'd8, 2'd0);
        run_instr(4'd14, 2'd0);

        // Random instruction stream
        for (int i = 0; i < 40; i++) begin
            run_instr(4'($urandom_range(14, 0)), 2'($urandom_range(3, 0)));
        end

        // HALT: retires once, then holds
        build(4'd15, 2'd0);
        chk("halt_fetch", {11'd0, vec_a}, {11'd0, exp_q[0]});
        op = 4'd15;
        @(negedge clk);
        chk("halt_decode", {11'd0, vec_a}, {11'd0, exp_q[1]});
        n_done++;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            op     = 4'($urandom_range(15, 0));
            cmpRst = 2'($urandom_range(3, 0));
            chk($sformatf("halt_hold%0d", i), {11'd0, vec_a}, {11'd0, pk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1)});
            chk_ret("halt_hold");
        end

        // Reset clears halt and counters without a clock edge
        #2 rst_n = 1'b0;
        #1;
        n_done = 0;
        chk("halt_rst_vec", {11'd0, vec_a}, 32'd0);
        chk_ret("halt_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Async reset in the middle of a store
        run_instr(4'd0, 2'd0);
        run_instr(4'd7, 2'd0);
        chk("sw_fetch", {31'd0, mr_a}, 32'd1);
        op = 4'd10;
        repeat (3) @(negedge clk);
        chk("sw_memwr", {31'd0, mw_a}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        n_done = 0;
        chk("sw_rst_mw", {31'd0, mw_a}, 32'd0);
        chk("sw_rst_vec", {11'd0, vec_a}, 32'd0);
        chk_ret("sw_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
